bin2bcd_seq: RTL



---
 rtl/bin2bcd_pkg.sv | 16 +
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bin2bcd_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam int DIGIT_W    = 4;
   localparam int ADJ_THRESH = 5;
   localparam int ADJ_ADD    = 3;
   localparam logic [3:0] BLANK_CODE = 4'hF;

   // Decimal digits needed for 2^width-1, i.e. ceil(width*log10(2)).
   function automatic int min_digits(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more (4-bit wrap).
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] d,
   output logic [DIGIT_W-1:0] q
);

   assign q = (d >= DIGIT_W'(ADJ_THRESH)) ? d + DIGIT_W'(ADJ_ADD) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one bit per clock; BIN2BCD_BLANK_EN blanks leading zeros.
// Result WIDTH+1 cycles after an accepted start; start is ignored while busy (no queueing).
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam bit OVF_POSSIBLE = (DIGITS < min_digits(WIDTH));

   state_t             state;
   logic [WIDTH-1:0]   bin_sh;
   logic [BCD_W-1:0]   digits;
   logic [BCD_W-1:0]   adj;
   logic [BCD_W-1:0]   nxt_digits;
   logic [BCD_W-1:0]   res_digits;
   logic [CNT_W-1:0]   cnt;
   logic               ovf_acc;
   logic               shout;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .d(digits[DIGIT_W*i +: DIGIT_W]),
         .q(adj[DIGIT_W*i +: DIGIT_W])
      );
   end

   // The adjusted top digit's MSB falls off the register: that is a lost 10^DIGITS.
   assign shout      = adj[BCD_W-1];
   assign nxt_digits = {adj[BCD_W-2:0], bin_sh[WIDTH-1]};

`ifdef BIN2BCD_BLANK_EN
   logic lead;
   always_comb begin
      res_digits = nxt_digits;
      lead       = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && nxt_digits[DIGIT_W*i +: DIGIT_W] == '0)
            res_digits[DIGIT_W*i +: DIGIT_W] = BLANK_CODE;
         else
            lead = 1'b0;
      end
   end
`else
   assign res_digits = nxt_digits;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd     <= '0;
         ovf     <= 1'b0;
         bin_sh  <= '0;
         digits  <= '0;
         cnt     <= '0;
         ovf_acc <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin_sh  <= bin;
                  digits  <= '0;
                  cnt     <= '0;
                  ovf_acc <= 1'b0;
                  state   <= SHIFT;
                  ready   <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            SHIFT: begin
               digits  <= nxt_digits;
               bin_sh  <= bin_sh << 1;
               ovf_acc <= ovf_acc | shout;
               cnt     <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  bcd   <= res_digits;
                  ovf   <= OVF_POSSIBLE && (ovf_acc || shout);
                  done  <= 1'b1;
                  state <= IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
